// File: rtl/cordic_polar_engine.sv
// Iterative multi-mode CORDIC: vectoring (atan2 + magnitude) or rotation, with
// optional gain compensation, saturating outputs and valid/ready handshakes.
module cordic_polar_engine #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int ITERS     = 16,
    parameter int GAIN_COMP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             out_sat
);
    localparam int IW = WIDTH + 2;
    localparam int PW = IW + 34;
    localparam int SH = 30 - FRAC;
    localparam logic [63:0] HALF_PI_Q30 = 64'd1686629713;
    localparam logic [63:0] K_Q30       = 64'd652032874;
    localparam logic signed [IW-1:0] P_HALF_PI = IW'(HALF_PI_Q30 >> SH);
    localparam logic signed [PW-1:0] P_KQ  = PW'((K_Q30 + (64'd1 << (SH - 1))) >> SH);
    localparam logic signed [PW-1:0] P_RND = PW'(64'd1 << (FRAC - 1));
    localparam logic signed [PW-1:0] P_MAX = PW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [PW-1:0] P_MIN = ~P_MAX;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_CALC, S_SCALE, S_HOLD} state_t;

    state_t                r_state, w_next;
    logic                  r_in_ready, r_mode, r_zero;
    logic [4:0]            r_iter;
    logic signed [IW-1:0]  r_x, r_y, r_z;
    logic signed [IW-1:0]  w_xs, w_ys, w_atan;
    logic                  w_d, w_accept, w_sat_x, w_sat_y;
    logic signed [PW-1:0]  w_px, w_py;
    logic [WIDTH-1:0]      w_ox, w_oy;

    function automatic logic [31:0] f_atan(input logic [4:0] i);
        case (i)
            5'd0:  return 32'h3243F6A9;
            5'd1:  return 32'h1DAC6705;
            5'd2:  return 32'h0FADBAFD;
            5'd3:  return 32'h07F56EA7;
            5'd4:  return 32'h03FEAB77;
            5'd5:  return 32'h01FFD55C;
            5'd6:  return 32'h00FFFAAB;
            5'd7:  return 32'h007FFF55;
            5'd8:  return 32'h003FFFEB;
            5'd9:  return 32'h001FFFFD;
            5'd10: return 32'h00100000;
            5'd11: return 32'h00080000;
            5'd12: return 32'h00040000;
            5'd13: return 32'h00020000;
            5'd14: return 32'h00010000;
            5'd15: return 32'h00008000;
            5'd16: return 32'h00004000;
            5'd17: return 32'h00002000;
            5'd18: return 32'h00001000;
            5'd19: return 32'h00000800;
            5'd20: return 32'h00000400;
            5'd21: return 32'h00000200;
            5'd22: return 32'h00000100;
            5'd23: return 32'h00000080;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic signed [PW-1:0] f_scale(input logic signed [IW-1:0] v);
        logic signed [PW-1:0] p;
        p = PW'(v);
        if (GAIN_COMP != 0) p = (p * P_KQ + P_RND) >>> FRAC;
        return p;
    endfunction

    assign w_accept  = r_in_ready & in_valid;
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == S_HOLD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_PRE;
            S_PRE:   w_next = S_CALC;
            S_CALC:  if (r_iter == 5'(ITERS - 1)) w_next = S_SCALE;
            S_SCALE: w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and the first edge after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_IDLE);
        end
    end

    always_comb begin
        w_d     = r_mode ? r_z[IW-1] : ~r_y[IW-1];
        w_xs    = r_x >>> r_iter;
        w_ys    = r_y >>> r_iter;
        w_atan  = IW'(f_atan(r_iter) >> SH);
        w_px    = f_scale(r_x);
        w_py    = f_scale(r_y);
        w_sat_x = (w_px > P_MAX) || (w_px < P_MIN);
        w_sat_y = (w_py > P_MAX) || (w_py < P_MIN);
        w_ox    = w_sat_x ? (w_px[PW-1] ? P_MIN[WIDTH-1:0] : P_MAX[WIDTH-1:0]) : w_px[WIDTH-1:0];
        w_oy    = w_sat_y ? (w_py[PW-1] ? P_MIN[WIDTH-1:0] : P_MAX[WIDTH-1:0]) : w_py[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 1'b0;
            r_zero  <= 1'b0;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            out_x   <= '0;
            out_y   <= '0;
            out_z   <= '0;
            out_sat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_mode <= mode;
                    r_x    <= IW'($signed(x_in));
                    r_y    <= IW'($signed(y_in));
                    r_z    <= IW'($signed(z_in));
                end
                S_PRE: begin
                    r_iter <= '0;
                    r_zero <= ~r_mode && (r_x == '0) && (r_y == '0);
                    // Quadrant pre-rotation by +/-90 degrees keeps CALC inside its convergence range
                    if (!r_mode) begin
                        if (!r_x[IW-1]) begin
                            r_z <= '0;
                        end else if (!r_y[IW-1]) begin
                            r_x <= r_y;
                            r_y <= -r_x;
                            r_z <= P_HALF_PI;
                        end else begin
                            r_x <= -r_y;
                            r_y <= r_x;
                            r_z <= -P_HALF_PI;
                        end
                    end else if (r_z > P_HALF_PI) begin
                        r_x <= -r_y;
                        r_y <= r_x;
                        r_z <= r_z - P_HALF_PI;
                    end else if (r_z < -P_HALF_PI) begin
                        r_x <= r_y;
                        r_y <= -r_x;
                        r_z <= r_z + P_HALF_PI;
                    end
                end
                S_CALC: begin
                    r_iter <= r_iter + 5'd1;
                    if (w_d) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                end
                S_SCALE: begin
                    out_x   <= w_ox;
                    out_y   <= w_oy;
                    out_z   <= r_zero ? '0 : r_z[WIDTH-1:0];
                    out_sat <= w_sat_x | w_sat_y;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_polar_engine.sv
// Scoreboard bench for cordic_polar_engine: default instance (Q16, 16 iters,
// gain compensated) and a narrow instance (W24, Q12, 12 iters, raw gain).
module tb_cordic_polar_engine;
    typedef struct {
        string  tag;
        longint ex, ey, ez;
        int     tx, ty, tz;
        int     esat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, mode, out_valid, out_ready, out_sat;
    logic [31:0] x_in, y_in, z_in, out_x, out_y, out_z;
    logic        in_valid2, in_ready2, mode2, out_valid2, out_ready2, out_sat2;
    logic [23:0] x_in2, y_in2, z_in2, out_x2, out_y2, out_z2;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t sb2[$];
    real  kraw;

    cordic_polar_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_sat(out_sat)
    );

    cordic_polar_engine #(.WIDTH(24), .FRAC(12), .ITERS(12), .GAIN_COMP(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .mode(mode2),
        .x_in(x_in2), .y_in(y_in2), .z_in(z_in2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_x(out_x2), .out_y(out_y2), .out_z(out_z2), .out_sat(out_sat2)
    );

    task automatic check_val(input string tag, input longint got, input longint exp, input int tol);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d > longint'(tol)) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    function automatic exp_t mk(input string tag, input longint ex, input int tx, input longint ey,
                                input int ty, input longint ez, input int tz, input int esat);
        exp_t e;
        e.tag = tag; e.ex = ex; e.ey = ey; e.ez = ez;
        e.tx = tx; e.ty = ty; e.tz = tz; e.esat = esat;
        return e;
    endfunction

    function automatic longint qr(input real v, input int f);
        return longint'($rtoi(v * (2.0 ** f) + ((v >= 0.0) ? 0.5 : -0.5)));
    endfunction

    task automatic score(input exp_t e, input longint ox, input longint oy, input longint oz, input int sat);
        if (e.tx >= 0) check_val({e.tag, "_x"}, ox, e.ex, e.tx);
        if (e.ty >= 0) check_val({e.tag, "_y"}, oy, e.ey, e.ty);
        if (e.tz >= 0) check_val({e.tag, "_z"}, oz, e.ez, e.tz);
        if (e.esat >= 0) check_val({e.tag, "_sat"}, longint'(sat), longint'(e.esat), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) check_val("d1_unexpected_out", longint'(out_valid), 0, 0);
            else begin
                e = sb.pop_front();
                score(e, $signed(out_x), $signed(out_y), $signed(out_z), int'(out_sat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid2 && out_ready2) begin
            if (sb2.size() == 0) check_val("d2_unexpected_out", longint'(out_valid2), 0, 0);
            else begin
                e = sb2.pop_front();
                score(e, $signed(out_x2), $signed(out_y2), $signed(out_z2), int'(out_sat2));
            end
        end
    end

    task automatic send1(input logic m, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input exp_t e);
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) check_val("d1_ready_timeout", longint'(in_ready), 1, 0);
        mode = m; x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic m, input logic [23:0] x, input logic [23:0] y,
                         input logic [23:0] z, input exp_t e);
        int n = 0;
        while (in_ready2 !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) check_val("d2_ready_timeout", longint'(in_ready2), 1, 0);
        mode2 = m; x_in2 = x; y_in2 = y; z_in2 = z; in_valid2 = 1'b1;
        sb2.push_back(e);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    task automatic wait_valid(input bit second, output int c);
        c = 0;
        while ((second ? out_valid2 : out_valid) !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    endtask

    task automatic drain;
        int n = 0;
        while ((sb.size() != 0 || sb2.size() != 0 || out_valid || out_valid2) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 1000) check_val("drain_timeout", longint'(sb.size() + sb2.size()), 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        int   c;
        real  vx[4] = '{0.5, -2.0, -1.5, 3.0};
        real  vy[4] = '{1.25, 0.75, -2.5, -0.25};
        real  rx[3] = '{1.0, -0.75, 2.0};
        real  ry[3] = '{0.5, 1.0, 0.0};
        real  rz[3] = '{2.5, -2.0, 0.3};
        real  xr, yr, zr;

        kraw = 1.0;
        for (int i = 0; i < 12; i++) kraw = kraw * $sqrt(1.0 + 2.0 ** (-2 * i));

        rst = 1'b1;
        in_valid = 1'b0; mode = 1'b0; x_in = '0; y_in = '0; z_in = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; mode2 = 1'b0; x_in2 = '0; y_in2 = '0; z_in2 = '0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", longint'(in_ready), 0, 0);
        check_val("rst_out_valid", longint'(out_valid), 0, 0);
        check_val("rst_out_x", longint'(out_x), 0, 0);
        check_val("rst_out_sat", longint'(out_sat), 0, 0);
        check_val("rst_in_ready2", longint'(in_ready2), 0, 0);
        rst = 1'b0;
        #1;
        check_val("rel_in_ready_low", longint'(in_ready), 0, 0);
        @(posedge clk); #1;
        check_val("rel_in_ready_high", longint'(in_ready), 1, 0);

        // Fixed vectors from hand-derived Q16 values
        send1(1'b0, 32'h00010000, 32'h00010000, '0, mk("v11", 32'h16A0A, 8, 0, -1, 32'hC90F, 4, 0));
        wait_valid(1'b0, c);
        check_val("v11_latency", longint'(c), 18, 0);
        drain();
        send1(1'b0, 32'hFFFF0000, '0, '0, mk("vneg", 65536, 8, 0, -1, 32'h3243F, 4, 0));
        send1(1'b0, '0, 32'hFFFF0000, '0, mk("vdown", 65536, 8, 0, -1, -102943, 4, 0));
        send1(1'b0, '0, '0, '0, mk("vzero", 0, 0, 0, 0, 0, 0, 0));
        send1(1'b1, 32'h00010000, '0, 32'h0001921F, mk("rot90", 0, 8, 65536, 8, 0, -1, 0));
        send1(1'b1, 32'h00010000, '0, 32'hFFFCDBC1, mk("rotpi", -65536, 8, 0, 8, 0, -1, 0));
        send1(1'b0, 32'h7FFF0000, 32'h7FFF0000, '0, mk("vsat", 32'h7FFFFFFF, 0, 0, -1, 32'hC90F, 4, 1));

        // Real-valued reference model, issued back to back
        for (int k = 0; k < 4; k++) begin
            xr = vx[k]; yr = vy[k];
            send1(1'b0, 32'(qr(xr, 16)), 32'(qr(yr, 16)), '0,
                  mk($sformatf("vmod%0d", k), qr($sqrt(xr * xr + yr * yr), 16), 16, 0, -1,
                     qr($atan2(yr, xr), 16), 8, 0));
        end
        for (int k = 0; k < 3; k++) begin
            xr = rx[k]; yr = ry[k]; zr = rz[k];
            send1(1'b1, 32'(qr(xr, 16)), 32'(qr(yr, 16)), 32'(qr(zr, 16)),
                  mk($sformatf("rmod%0d", k), qr(xr * $cos(zr) - yr * $sin(zr), 16), 16,
                     qr(xr * $sin(zr) + yr * $cos(zr), 16), 16, 0, -1, 0));
        end
        drain();

        // Backpressure with ignored in_valid pulses while holding
        out_ready = 1'b0;
        send1(1'b0, 32'h00010000, '0, '0, mk("bp", 65536, 8, 0, -1, 0, 4, 0));
        wait_valid(1'b0, c);
        check_val("bp_latency", longint'(c), 18, 0);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; mode = 1'b1; x_in = $urandom; y_in = $urandom; z_in = '0;
            @(posedge clk); #1;
            check_val("bp_valid_held", longint'(out_valid), 1, 0);
            check_val("bp_in_ready_low", longint'(in_ready), 0, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_valid_drop", longint'(out_valid), 0, 0);
        @(posedge clk); #1;
        check_val("bp_in_ready_back", longint'(in_ready), 1, 0);
        repeat (22) @(posedge clk);
        #1;
        check_val("bp_no_ghost", longint'(out_valid), 0, 0);

        // Reset during CALC step 7, then a clean operation
        send1(1'b0, 32'h00030000, 32'h00020000, '0, mk("aborted", 0, -1, 0, -1, 0, -1, -1));
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_out_x", longint'(out_x), 0, 0);
        check_val("abort_out_z", longint'(out_z), 0, 0);
        check_val("abort_out_valid", longint'(out_valid), 0, 0);
        check_val("abort_in_ready", longint'(in_ready), 0, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send1(1'b0, 32'h00008000, 32'h00014000, '0,
              mk("post_abort", qr($sqrt(0.25 + 1.5625), 16), 16, 0, -1, qr($atan2(1.25, 0.5), 16), 8, 0));
        drain();

        // Narrow instance: W24 Q12, 12 iterations, raw CORDIC gain
        send2(1'b0, 24'h001000, 24'h001000, '0,
              mk("d2_v11", qr(kraw * $sqrt(2.0), 12), 8, 0, -1, qr(3.14159265358979 / 4.0, 12), 12, 0));
        wait_valid(1'b1, c);
        check_val("d2_latency", longint'(c), 14, 0);
        send2(1'b1, 24'h001000, '0, 24'(qr(1.5707963, 12)), mk("d2_rot90", 0, 8, qr(kraw, 12), 8, 0, -1, 0));
        drain();
        send2(1'b0, 24'h003000, 24'h001000, '0, mk("d2_aborted", 0, -1, 0, -1, 0, -1, -1));
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("d2_abort_out_x", longint'(out_x2), 0, 0);
        check_val("d2_abort_out_y", longint'(out_y2), 0, 0);
        check_val("d2_abort_out_valid", longint'(out_valid2), 0, 0);
        sb2.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send2(1'b0, 24'hFFF000, '0, '0, mk("d2_post_abort", qr(kraw, 12), 12, 0, -1, qr(3.14159265358979, 12), 12, 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
